memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum wait cycles for mem_ready before abort; legal range 1..1023.
REQ-002 The block SHALL have these ports, clock and reset first:
  clk  in  1  sole clock; all state on its rising edge
  resetn  in  1  asynchronous active-low reset
  ValidM  in  1  instruction in MEM is valid
  MemReadM  in  1  load
  MemWriteM  in  1  store
  LoadOpM  in  LoadOp_t  load width/sign
  StoreOpM  in  StoreOp_t  SB/SH/SW
  AluResultM  in  32  effective address / ALU result
  WriteDataM  in  32  store source (rs2)
  RdM  in  5  destination register
  RegWriteM  in  1  writes rd
  mem_valid  out  1  bus request
  mem_ready  in  1  bus completion
  mem_addr  out  32  word-aligned address
  mem_wdata  out  32  lane-aligned store data
  mem_wstrb  out  4  byte strobes, 0 for loads
  mem_rdata  in  32  raw load word, valid with mem_ready
  StallM  out  1  hold EX/MEM and upstream
  ValidW  out  1  MEM/WB bundle valid
  RegWriteW  out  1
  RdW  out  5
  AluResultW  out  32
  LoadOpW  out  LoadOp_t
  ReadDataW  out  32  raw word for load alignment in WB
  BusErrW  out  1  access timed out
  MisalignW  out  1  misaligned access trap

Function
REQ-003 FSM states SHALL be IDLE and REQ only.
REQ-004 In IDLE, for ValidM with neither MemReadM nor MemWriteM, the block SHALL register the bundle into the W outputs next edge (latency 1) with StallM=0.
REQ-005 In IDLE, for ValidM with MemReadM or MemWriteM and no trap, the block SHALL assert StallM combinationally, register mem_addr/mem_wdata/mem_wstrb, and enter REQ.
REQ-006 In REQ, mem_valid SHALL be 1, and mem_addr/mem_wdata/mem_wstrb SHALL stay stable until the cycle in which mem_ready=1.
REQ-007 In the REQ cycle with mem_ready=1, StallM SHALL be 0; at that edge ReadDataW SHALL capture mem_rdata, the W bundle SHALL update with ValidW=1, and the state SHALL return to IDLE (minimum memory latency 2 cycles).
REQ-008 In REQ without mem_ready, StallM SHALL be 1 and the wait counter SHALL increment.
REQ-009 When the wait counter reaches TIMEOUT_CYCLES, the block SHALL drop mem_valid, go to IDLE, and emit ValidW=1, BusErrW=1 and RegWriteW=0; a mem_ready arriving in that same cycle SHALL win (normal completion).
REQ-010 When stalled or when ValidM=0, the W outputs SHALL be a bubble: ValidW=0, RegWriteW=0, BusErrW=0, MisalignW=0.
REQ-011 mem_addr SHALL equal {AluResultM[31:2],2'b00}.
REQ-012 Store lanes: SB gives wstrb=1<<addr[1:0] with the byte replicated ×4; SH gives wstrb=0011 or 1100 selected by addr[1] with the halfword replicated ×2; SW gives wstrb=1111.
REQ-013 Loads SHALL drive mem_wstrb=0000.
REQ-014 Misalignment is defined as halfword access with addr[0]=1, or word access with addr[1:0]≠0.

Reset
REQ-015 While resetn=0, the state SHALL be IDLE and the counter 0, with mem_valid, mem_addr, mem_wdata, mem_wstrb, StallM, and all W outputs at 0 (LoadOpW at its encoding 0).
REQ-016 Reset asserted mid-REQ SHALL drop mem_valid immediately and asynchronously, and the transaction SHALL be abandoned.

Configuration
REQ-017 With MISALIGN_TRAP_EN defined, a misaligned access SHALL NOT reach the bus, SHALL take 1 cycle with StallM=0, and SHALL produce ValidW=1, MisalignW=1, RegWriteW=0.
REQ-018 Without MISALIGN_TRAP_EN, MisalignW SHALL be tied to 0, and a misaligned access SHALL be issued per REQ-011/012 using the in-word lanes only.

Structure
REQ-019 LoadOp_t, StoreOp_t and the FSM state enum SHALL live in the shared riscv_defines package/header.
REQ-020 Lane/strobe generation SHALL be a combinational sub-module, store_alignment, the counterpart of load_alignment.

Verification
REQ-021 SW of 0xDEADBEEF to 0x100 with mem_ready after 3 wait cycles -> mem_valid high 4 cycles, addr 0x100, wstrb 1111, StallM releases in the ready cycle.
REQ-022 SB of WriteDataM=0x000000A5 at 0x103 -> wstrb 1000, wdata 0xA5A5A5A5.
REQ-023 LW at 0x40 with mem_rdata=0x12345678 and zero-wait ready -> next edge ReadDataW=0x12345678, ValidW=1, AluResultW=0x40.
REQ-024 TIMEOUT_CYCLES=4 with no mem_ready -> after 4 wait cycles mem_valid=0, BusErrW=1, RegWriteW=0.
REQ-025 With MISALIGN_TRAP_EN, LH at 0x201 -> no mem_valid, MisalignW=1 one cycle later; without the macro, a 0x201 request is issued to 0x200.
REQ-026 resetn pulsed low in REQ -> mem_valid=0 immediately, state IDLE, all W outputs 0.

Source files
------------

// File: rtl/riscv_defines_pkg.sv
// Shared RISC-V pipeline types: load/store op encodings, MEM-stage FSM states
// and the access-size helpers used for alignment checks.
package riscv_defines;

  typedef enum logic [2:0] {
    LOAD_LB  = 3'd0,
    LOAD_LH  = 3'd1,
    LOAD_LW  = 3'd2,
    LOAD_LBU = 3'd3,
    LOAD_LHU = 3'd4
  } LoadOp_t;

  typedef enum logic [1:0] {
    STORE_SB = 2'd0,
    STORE_SH = 2'd1,
    STORE_SW = 2'd2
  } StoreOp_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } access_size_t;

  // Wide enough for the largest legal timeout (1023).
  typedef logic [9:0] wait_cnt_t;

  function automatic access_size_t load_size(input LoadOp_t op);
    case (op)
      LOAD_LH, LOAD_LHU: return SIZE_H;
      LOAD_LW:           return SIZE_W;
      default:           return SIZE_B;
    endcase
  endfunction

  function automatic access_size_t store_size(input StoreOp_t op);
    case (op)
      STORE_SH: return SIZE_H;
      STORE_SW: return SIZE_W;
      default:  return SIZE_B;
    endcase
  endfunction

  function automatic logic is_misaligned(input access_size_t sz, input logic [1:0] lo);
    return ((sz == SIZE_H) && lo[0]) || ((sz == SIZE_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/memory_stage_store_alignment.sv
// store_alignment: places store data on its byte lanes and builds the write
// strobes; counterpart of load_alignment in WB.
module store_alignment
  import riscv_defines::*;
(
  input  StoreOp_t    store_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] lane_data,
  output logic [3:0]  strb
);

  always_comb begin
    lane_data = '0;
    strb      = '0;
    case (store_op)
      STORE_SB: begin
        lane_data = {4{data[7:0]}};
        strb      = 4'b0001 << addr_lo;
      end
      STORE_SH: begin
        lane_data = {2{data[15:0]}};
        strb      = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      STORE_SW: begin
        lane_data = data;
        strb      = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage with a single outstanding bus access and a
// wait-cycle timeout. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module memory_stage
  import riscv_defines::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ValidM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  LoadOp_t     LoadOpM,
  input  StoreOp_t    StoreOpM,
  input  logic [31:0] AluResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic        ValidW,
  output logic        RegWriteW,
  output logic [4:0]  RdW,
  output logic [31:0] AluResultW,
  output LoadOp_t     LoadOpW,
  output logic [31:0] ReadDataW,
  output logic        BusErrW,
  output logic        MisalignW
);

  localparam wait_cnt_t TIMEOUT_LAST = wait_cnt_t'(TIMEOUT_CYCLES - 1);

  // Bus handshake: mem_valid is held with stable addr/wdata/wstrb from the
  // first REQ cycle until the cycle in which mem_ready=1 (or the timeout).
  mem_state_t  state, state_next;
  wait_cnt_t   wait_cnt;
  logic        is_mem, trap, issue, pass, done, timeout;
  logic [31:0] lane_data;
  logic [3:0]  lane_strb;
  logic [4:0]  req_rd;
  logic        req_regwrite;
  logic [31:0] req_alu;
  LoadOp_t     req_loadop;

  store_alignment u_store_alignment (
    .store_op  (StoreOpM),
    .addr_lo   (AluResultM[1:0]),
    .data      (WriteDataM),
    .lane_data (lane_data),
    .strb      (lane_strb)
  );

  assign is_mem = MemReadM | MemWriteM;

`ifdef MISALIGN_TRAP_EN
  access_size_t acc_size;
  assign acc_size = MemWriteM ? store_size(StoreOpM) : load_size(LoadOpM);
  assign trap     = (state == IDLE) & ValidM & is_mem & is_misaligned(acc_size, AluResultM[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign issue   = (state == IDLE) & ValidM & is_mem & ~trap;
  assign pass    = (state == IDLE) & ValidM & ~is_mem;
  assign done    = (state == REQ) & mem_ready;
  assign timeout = (state == REQ) & ~mem_ready & (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue) state_next = REQ;
      REQ:     if (done || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // StallM is also forced low during reset so upstream sees a clean pipeline.
  always_comb begin
    mem_valid = 1'b0;
    StallM    = 1'b0;
    if (resetn) begin
      case (state)
        IDLE: StallM = issue;
        REQ: begin
          mem_valid = 1'b1;
          StallM    = ~mem_ready & ~timeout;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt     <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      req_rd       <= '0;
      req_regwrite <= 1'b0;
      req_alu      <= '0;
      req_loadop   <= LOAD_LB;
    end else if (issue) begin
      wait_cnt     <= '0;
      mem_addr     <= {AluResultM[31:2], 2'b00};
      mem_wdata    <= lane_data;
      mem_wstrb    <= MemWriteM ? lane_strb : 4'b0000;
      req_rd       <= RdM;
      req_regwrite <= RegWriteM;
      req_alu      <= AluResultM;
      req_loadop   <= LoadOpM;
    end else if ((state == REQ) && !mem_ready && !timeout) begin
      wait_cnt <= wait_cnt + wait_cnt_t'(1);
    end
  end

  // W bundle: bubble by default, loaded on pass-through, trap, completion or timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ValidW     <= 1'b0;
      RegWriteW  <= 1'b0;
      RdW        <= '0;
      AluResultW <= '0;
      LoadOpW    <= LOAD_LB;
      ReadDataW  <= '0;
      BusErrW    <= 1'b0;
      MisalignW  <= 1'b0;
    end else begin
      ValidW    <= 1'b0;
      RegWriteW <= 1'b0;
      BusErrW   <= 1'b0;
      MisalignW <= 1'b0;
      if (pass || trap) begin
        ValidW     <= 1'b1;
        RegWriteW  <= RegWriteM & ~trap;
        MisalignW  <= trap;
        RdW        <= RdM;
        AluResultW <= AluResultM;
        LoadOpW    <= LoadOpM;
      end else if (done || timeout) begin
        ValidW     <= 1'b1;
        RegWriteW  <= req_regwrite & done;
        BusErrW    <= timeout;
        RdW        <= req_rd;
        AluResultW <= req_alu;
        LoadOpW    <= req_loadop;
        if (done) ReadDataW <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed cases plus randomized ALU,
// load and store traffic against a behavioural model of the bus and W bundle.
module tb_memory_stage;
  import riscv_defines::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ValidM, MemReadM, MemWriteM, RegWriteM;
  LoadOp_t     LoadOpM;
  StoreOp_t    StoreOpM;
  logic [31:0] AluResultM, WriteDataM;
  logic [4:0]  RdM;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        StallM, ValidW, RegWriteW, BusErrW, MisalignW;
  logic [4:0]  RdW;
  logic [31:0] AluResultW, ReadDataW;
  LoadOp_t     LoadOpW;

  memory_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn), .ValidM(ValidM), .MemReadM(MemReadM),
    .MemWriteM(MemWriteM), .LoadOpM(LoadOpM), .StoreOpM(StoreOpM),
    .AluResultM(AluResultM), .WriteDataM(WriteDataM), .RdM(RdM),
    .RegWriteM(RegWriteM), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .StallM(StallM), .ValidW(ValidW),
    .RegWriteW(RegWriteW), .RdW(RdW), .AluResultW(AluResultW),
    .LoadOpW(LoadOpW), .ReadDataW(ReadDataW), .BusErrW(BusErrW),
    .MisalignW(MisalignW)
  );

  // clock/reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // behavioural model
  function automatic int size_bytes(input int kind, input logic [2:0] lop, input logic [1:0] sop);
    if (kind == 2) return (sop == 0) ? 1 : (sop == 1) ? 2 : 4;
    return (lop == 2) ? 4 : ((lop == 1) || (lop == 4)) ? 2 : 1;
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] sop, input logic [31:0] addr);
    if (sop == 0) return 4'(1 << (addr % 4));
    if (sop == 1) return ((addr % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sop, input logic [31:0] wd);
    if (sop == 0) return (wd % 256) * 32'h0101_0101;
    if (sop == 1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  task automatic idle_inputs();
    ValidM = 0; MemReadM = 0; MemWriteM = 0; RegWriteM = 0;
    LoadOpM = LOAD_LB; StoreOpM = STORE_SB; AluResultM = '0;
    WriteDataM = '0; RdM = '0; mem_ready = 0; mem_rdata = '0;
  endtask

  // driver: kind 0=ALU, 1=load, 2=store; waits>=TMO means mem_ready never comes
  task automatic do_op(input int kind, input logic [2:0] lop, input logic [1:0] sop,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input int waits);
    logic trap, mis, rw, timed_out;
    int   sz, mv;
    logic [31:0] rdata;
    sz  = size_bytes(kind, lop, sop);
    mis = (kind != 0) && ((addr % sz) != 0);
`ifdef MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
`endif
    rw = (kind == 1) ? 1'b1 : (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    ValidM = 1; MemReadM = (kind == 1); MemWriteM = (kind == 2);
    LoadOpM = LoadOp_t'(lop); StoreOpM = StoreOp_t'(sop); AluResultM = addr;
    WriteDataM = wd; RdM = rd; RegWriteM = rw; mem_ready = 0;
    #2;
    check("mem_valid_issue", mem_valid, 0);
    if (kind == 0 || trap) begin
      check("stall_single", StallM, 0);
      @(posedge clk); #1;
      ValidM = 0;
      check("mem_valid_single", mem_valid, 0);
      check("validw_single", ValidW, 1);
      check("regwritew_single", RegWriteW, trap ? 1'b0 : rw);
      check("misalignw_single", MisalignW, trap);
      check("buserrw_single", BusErrW, 0);
      check("rdw_single", RdW, rd);
      check("aluw_single", AluResultW, addr);
      check("loadopw_single", LoadOpW, lop);
    end else begin
      check("stall_issue", StallM, 1);
      mv = 0;
      for (int c = 0; c < TMO; c++) begin
        @(posedge clk); #1;
        mv += int'(mem_valid);
        check("validw_stalled", ValidW, 0);
        check("mem_addr", mem_addr, (addr / 4) * 4);
        check("mem_wstrb", mem_wstrb, (kind == 2) ? model_strb(sop, addr) : 4'h0);
        if (kind == 2) check("mem_wdata", mem_wdata, model_wdata(sop, wd));
        if (c == waits) begin
          rdata = $urandom;
          mem_ready = 1; mem_rdata = rdata;
          exp_q.push_back(rdata);
          #2;
          check("stall_ready", StallM, 0);
          break;
        end
        #2;
        check("stall_wait", StallM, (c == TMO - 1) ? 1'b0 : 1'b1);
      end
      timed_out = (waits >= TMO);
      @(posedge clk); #1;
      ValidM = 0; mem_ready = 0;
      check("mem_valid_done", mem_valid, 0);
      check("mem_valid_cycles", mv, timed_out ? TMO : waits + 1);
      check("validw_done", ValidW, 1);
      check("buserrw_done", BusErrW, timed_out);
      check("regwritew_done", RegWriteW, timed_out ? 1'b0 : rw);
      check("misalignw_done", MisalignW, 0);
      check("rdw_done", RdW, rd);
      check("aluw_done", AluResultW, addr);
      check("loadopw_done", LoadOpW, lop);
      if (!timed_out && exp_q.size() > 0) check("readdataw", ReadDataW, exp_q.pop_front());
    end
    @(posedge clk); #1;
    check("bubble_validw", ValidW, 0);
    check("bubble_regwritew", RegWriteW, 0);
    check("bubble_buserrw", BusErrW, 0);
    check("bubble_misalignw", MisalignW, 0);
  endtask

  task automatic reset_mid_req();
    @(posedge clk); #1;
    ValidM = 1; MemWriteM = 1; StoreOpM = STORE_SW; AluResultM = 32'h300;
    WriteDataM = 32'hCAFE_F00D; RdM = 5'd3; RegWriteM = 0;
    @(posedge clk); #1;
    check("rst_mem_valid_before", mem_valid, 1);
    #2;
    resetn = 0;
    #1;
    check("rst_mem_valid", mem_valid, 0);
    check("rst_stall", StallM, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    check("rst_validw", ValidW, 0);
    check("rst_regwritew", RegWriteW, 0);
    check("rst_rdw", RdW, 0);
    check("rst_aluw", AluResultW, 0);
    check("rst_loadopw", LoadOpW, 0);
    check("rst_readdataw", ReadDataW, 0);
    check("rst_buserrw", BusErrW, 0);
    check("rst_misalignw", MisalignW, 0);
    idle_inputs();
    @(negedge clk);
    resetn = 1;
  endtask

  initial begin
    resetn = 0;
    idle_inputs();
    #12;
    check("init_mem_valid", mem_valid, 0);
    check("init_stall", StallM, 0);
    check("init_validw", ValidW, 0);
    check("init_mem_wstrb", mem_wstrb, 0);
    check("init_loadopw", LoadOpW, 0);
    @(negedge clk);
    resetn = 1;

    do_op(2, 3'd0, 2'd2, 32'h100, 32'hDEAD_BEEF, 5'd0, 3);   // SW, 3 wait cycles
    do_op(2, 3'd0, 2'd0, 32'h103, 32'h0000_00A5, 5'd0, 0);   // SB to lane 3
    do_op(1, 3'd2, 2'd0, 32'h40,  32'h0,         5'd7, 0);   // LW zero-wait
    do_op(2, 3'd0, 2'd2, 32'h10,  32'h1234_5678, 5'd0, TMO); // timeout
    do_op(1, 3'd1, 2'd0, 32'h201, 32'h0,         5'd9, 1);   // LH misaligned
    do_op(0, 3'd0, 2'd0, 32'hABCD_0123, 32'h0,   5'd31, 0);  // ALU pass-through
    reset_mid_req();
    do_op(1, 3'd4, 2'd0, 32'h522, 32'h0, 5'd12, 2);

    for (int i = 0; i < 40; i++) begin
      do_op(int'($urandom_range(0, 2)), 3'($urandom_range(0, 4)), 2'($urandom_range(0, 2)),
            $urandom, $urandom, 5'($urandom_range(0, 31)), int'($urandom_range(0, TMO)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
